// File: rtl/freq_gate_counter_if.sv
// freq_gate_counter_if
//
// Bundles the sample stream coming from the ADC capture logic with the
// frequency result going to the BCD / seven-segment stage.
//
// Signals:
//   sample_en   ADC side -> meter : one-cycle strobe, ad_data holds a new sample
//   ad_data     ADC side -> meter : unsigned 8-bit sample, mid-scale 128
//   freq_hz     meter -> display  : edge count of the last completed window
//   freq_valid  meter -> display  : one-cycle pulse when freq_hz updates
//   freq_ovf    meter -> display  : last window's edge count saturated
//   no_signal   meter -> display  : last window counted zero edges
//
// Modports:
//   master  sample producer / result consumer (ADC capture + display path)
//   slave   the frequency meter itself
interface freq_gate_counter_if #(
    parameter int CNT_W = 27
);
    logic             sample_en;
    logic [7:0]       ad_data;
    logic [CNT_W-1:0] freq_hz;
    logic             freq_valid;
    logic             freq_ovf;
    logic             no_signal;

    modport master (
        output sample_en,
        output ad_data,
        input  freq_hz,
        input  freq_valid,
        input  freq_ovf,
        input  no_signal
    );

    modport slave (
        input  sample_en,
        input  ad_data,
        output freq_hz,
        output freq_valid,
        output freq_ovf,
        output no_signal
    );
endinterface

// File: rtl/freq_gate_counter.sv
// freq_gate_counter
//
// Measurement front-end of the frequency meter. A hysteresis comparator
// turns the ADC sample stream into a clean two-level signal and flags its
// rising crossings; a free-running gate counter defines a window of
// GATE_CYCLES clocks over which those crossings are counted. At the end of
// each window the (saturated) count is latched as freq_hz and announced
// with a one-cycle freq_valid pulse.
//
// Ports:
//   clk   system clock
//   rstn  asynchronous, active-low reset
//   bus   freq_gate_counter_if.slave: sample_en/ad_data in,
//         freq_hz/freq_valid/freq_ovf/no_signal out
//
// Parameters:
//   GATE_CYCLES  window length in clk cycles (1 s at 50 MHz -> count is Hz)
//   HYST_HI      sample >= HYST_HI drives the comparator HIGH
//   HYST_LO      sample <= HYST_LO drives the comparator LOW
//                (HYST_LO must be below HYST_HI)
//   CNT_W        width of the edge counter and of freq_hz
module freq_gate_counter #(
    parameter int         GATE_CYCLES = 50_000_000,
    parameter logic [7:0] HYST_HI     = 8'd160,
    parameter logic [7:0] HYST_LO     = 8'd96,
    parameter int         CNT_W       = 27
) (
    input  logic                   clk,
    input  logic                   rstn,
    freq_gate_counter_if.slave     bus
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_LOW,
        ST_HIGH
    } cmp_state_t;

    // Add a single increment in CNT_W+1 bits so the carry out is visible.
    function automatic logic [CNT_W:0] wide_add(input logic [CNT_W-1:0] a,
                                                input logic inc);
        return {1'b0, a} + {{CNT_W{1'b0}}, inc};
    endfunction

    // Clamp a CNT_W+1 bit sum to all-ones when its MSB is set.
    function automatic logic [CNT_W-1:0] sat_clamp(input logic [CNT_W:0] s);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    cmp_state_t        cmp_state_p0;
    logic              edge_inc_p0;
    logic [GATE_W-1:0] gate_cnt_p1;
    logic              terminal_p1;
    logic [CNT_W-1:0]  edge_cnt_p1;
    logic              sat_p1;
    logic [CNT_W:0]    cnt_sum_p1;
    logic [CNT_W-1:0]  cnt_clamp_p1;
    logic [CNT_W-1:0]  freq_hz_p2;
    logic              vld_p2;
    logic              freq_ovf_p2;
    logic              no_signal_p2;

    // ---- stage p0: hysteresis comparator / rising-edge detect ----
    // The edge flag is a same-cycle decode so the crossing lands in the
    // edge counter on the very next clock.
    always_comb begin
        edge_inc_p0 = bus.sample_en && (cmp_state_p0 == ST_LOW) &&
                      (bus.ad_data >= HYST_HI);
    end

    // State persists across windows; only reset returns it to INIT, and a
    // first crossing out of INIT is never counted as an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmp_state_p0 <= ST_INIT;
        end else if (bus.sample_en) begin
            case (cmp_state_p0)
                ST_INIT: begin
                    if (bus.ad_data >= HYST_HI)
                        cmp_state_p0 <= ST_HIGH;
                    else if (bus.ad_data <= HYST_LO)
                        cmp_state_p0 <= ST_LOW;
                end
                ST_LOW: begin
                    if (bus.ad_data >= HYST_HI)
                        cmp_state_p0 <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (bus.ad_data <= HYST_LO)
                        cmp_state_p0 <= ST_LOW;
                end
                default: cmp_state_p0 <= ST_INIT;
            endcase
        end
    end

    // ---- stage p1: gate window and saturating edge counter ----
    always_comb begin
        terminal_p1  = (gate_cnt_p1 == GATE_LAST);
        cnt_sum_p1   = wide_add(edge_cnt_p1, edge_inc_p0);
        cnt_clamp_p1 = sat_clamp(cnt_sum_p1);
    end

    // On the terminal cycle the count including that cycle's edge is
    // closed out, so an edge there belongs to the window that is ending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gate_cnt_p1  <= '0;
            edge_cnt_p1  <= '0;
            sat_p1       <= 1'b0;
            freq_hz_p2   <= '0;
            vld_p2       <= 1'b0;
            freq_ovf_p2  <= 1'b0;
            no_signal_p2 <= 1'b0;
        end else if (terminal_p1) begin
            gate_cnt_p1  <= '0;
            edge_cnt_p1  <= '0;
            sat_p1       <= 1'b0;
    // ---- stage p2: result latch ----
            freq_hz_p2   <= cnt_clamp_p1;
            vld_p2       <= 1'b1;
            freq_ovf_p2  <= sat_p1 | cnt_sum_p1[CNT_W];
            no_signal_p2 <= (cnt_clamp_p1 == '0);
        end else begin
            gate_cnt_p1  <= gate_cnt_p1 + 1'b1;
            edge_cnt_p1  <= cnt_clamp_p1;
            // A carry out means an increment was attempted at all-ones.
            if (cnt_sum_p1[CNT_W])
                sat_p1 <= 1'b1;
            vld_p2       <= 1'b0;
        end
    end

    assign bus.freq_hz    = freq_hz_p2;
    assign bus.freq_valid = vld_p2;
    assign bus.freq_ovf   = freq_ovf_p2;
    assign bus.no_signal  = no_signal_p2;

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter
//
// Drives two meters (wide counter and a 4-bit counter that saturates) with
// the same sample stream. A behavioural model tracks the comparator and the
// window; at each window end it pushes the expected result into a queue,
// which is popped and compared whenever the DUT strobes freq_valid.
module tb_freq_gate_counter;
    localparam int G  = 1000;
    localparam int WA = 27;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    freq_gate_counter_if #(.CNT_W(WA)) ifa ();
    freq_gate_counter_if #(.CNT_W(WB)) ifb ();

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(WA)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifa)
    );

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(WB)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifb)
    );

    typedef struct {
        longint hz_a;
        bit     ovf_a;
        bit     ns_a;
        longint hz_b;
        bit     ovf_b;
        bit     ns_b;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Model state: 0 = init, 1 = low, 2 = high
    int m_state;
    int m_gate;
    int m_cnt;
    bit m_valid;

    longint cap_a = (64'd1 << WA) - 1;
    longint cap_b = (64'd1 << WB) - 1;

    task automatic check_eq(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int w);
        case (p)
            0:       return ((w / 25) % 2 == 0) ? 8'd200 : 8'd50;
            1:       return ((w / 50) % 2 == 0) ? 8'd200 : 8'd50;
            2:       return (w % 2 == 0) ? 8'd130 : 8'd120;
            3:       return (w == G - 1) ? 8'd200 : 8'd50;
            default: return 8'd200;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_gate  = 0;
        m_cnt   = 0;
        m_valid = 0;
        sb.delete();
    endtask

    task automatic model_tick(input bit en, input logic [7:0] d);
        bit   inc;
        int   n;
        exp_t e;
        inc = 0;
        if (en) begin
            if (m_state == 0) begin
                if (d >= 160)     m_state = 2;
                else if (d <= 96) m_state = 1;
            end else if (m_state == 1) begin
                if (d >= 160) begin
                    m_state = 2;
                    inc = 1;
                end
            end else begin
                if (d <= 96) m_state = 1;
            end
        end
        if (m_gate == G - 1) begin
            n = m_cnt + int'(inc);
            e.hz_a  = (n > cap_a) ? cap_a : longint'(n);
            e.ovf_a = (n > cap_a);
            e.ns_a  = (e.hz_a == 0);
            e.hz_b  = (n > cap_b) ? cap_b : longint'(n);
            e.ovf_b = (n > cap_b);
            e.ns_b  = (e.hz_b == 0);
            sb.push_back(e);
            m_cnt   = 0;
            m_gate  = 0;
            m_valid = 1;
        end else begin
            m_cnt   = m_cnt + int'(inc);
            m_gate  = m_gate + 1;
            m_valid = 0;
        end
    endtask

    task automatic drive(input bit en, input logic [7:0] d);
        ifa.sample_en = en;
        ifa.ad_data   = d;
        ifb.sample_en = en;
        ifb.ad_data   = d;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_hz_a"},  ifa.freq_hz,    0);
        check_eq({tag, "_vld_a"}, ifa.freq_valid, 0);
        check_eq({tag, "_ovf_a"}, ifa.freq_ovf,   0);
        check_eq({tag, "_ns_a"},  ifa.no_signal,  0);
        check_eq({tag, "_hz_b"},  ifb.freq_hz,    0);
        check_eq({tag, "_vld_b"}, ifb.freq_valid, 0);
        check_eq({tag, "_ovf_b"}, ifb.freq_ovf,   0);
        check_eq({tag, "_ns_b"},  ifb.no_signal,  0);
    endtask

    // Called just after a rising edge; applies one sample and checks the
    // outputs just after the following edge.
    task automatic run(input int p, input bit en, input int nsteps);
        exp_t e;
        for (int w = 0; w < nsteps; w++) begin
            drive(en, pat(p, w));
            model_tick(en, pat(p, w));
            @(posedge clk);
            #1;
            check_eq("valid_a", ifa.freq_valid, m_valid);
            check_eq("valid_b", ifb.freq_valid, m_valid);
            if (ifa.freq_valid) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("hz_a",  ifa.freq_hz,   e.hz_a);
                    check_eq("ovf_a", ifa.freq_ovf,  e.ovf_a);
                    check_eq("ns_a",  ifa.no_signal, e.ns_a);
                    check_eq("hz_b",  ifb.freq_hz,   e.hz_b);
                    check_eq("ovf_b", ifb.freq_ovf,  e.ovf_b);
                    check_eq("ns_b",  ifb.no_signal, e.ns_b);
                end
            end
        end
    endtask

    initial begin
        // Reset held with live random samples
        rstn = 1'b0;
        model_reset();
        drive(1'b1, 8'($urandom_range(0, 255)));
        #1;
        check_zero("rst");
        repeat (4) begin
            @(posedge clk);
            #1;
            drive(1'b1, 8'($urandom_range(0, 255)));
            check_zero("rst_hold");
        end
        rstn = 1'b1;

        // 200/50 square, 25 cycles per level
        run(0, 1'b1, G);
        check_eq("sq_w1_hz_a",  ifa.freq_hz,   19);
        check_eq("sq_w1_ovf_a", ifa.freq_ovf,  0);
        check_eq("sq_w1_ns_a",  ifa.no_signal, 0);
        check_eq("sq_w1_hz_b",  ifb.freq_hz,   15);
        check_eq("sq_w1_ovf_b", ifb.freq_ovf,  1);
        run(0, 1'b1, G);
        check_eq("sq_w2_hz_a",  ifa.freq_hz,   20);
        check_eq("sq_w2_hz_b",  ifb.freq_hz,   15);
        check_eq("sq_w2_ovf_b", ifb.freq_ovf,  1);
        run(0, 1'b1, G);
        check_eq("sq_w3_hz_a",  ifa.freq_hz,   20);

        // Slower square: 10 edges per window, clears the overflow
        run(1, 1'b1, G);
        check_eq("slow_hz_a",  ifa.freq_hz,  10);
        check_eq("slow_hz_b",  ifb.freq_hz,  10);
        check_eq("slow_ovf_b", ifb.freq_ovf, 0);

        // Reset mid-window at gate count 400
        run(0, 1'b1, 400);
        rstn = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        check_zero("midrst_hold");
        rstn = 1'b1;
        run(0, 1'b1, G);
        check_eq("postrst_hz_a", ifa.freq_hz, 19);

        // Noise between the thresholds
        run(2, 1'b1, G);
        check_eq("noise1_hz_a", ifa.freq_hz,   0);
        check_eq("noise1_ns_a", ifa.no_signal, 1);
        run(2, 1'b1, G);
        check_eq("noise2_hz_a", ifa.freq_hz,   0);
        check_eq("noise2_ns_a", ifa.no_signal, 1);

        // sample_en held low
        run(0, 1'b0, G);
        check_eq("gated_hz_a", ifa.freq_hz,   0);
        check_eq("gated_ns_a", ifa.no_signal, 1);

        // Rising edge on the terminal cycle
        run(3, 1'b1, G);
        check_eq("term_hz_a", ifa.freq_hz,   1);
        check_eq("term_ns_a", ifa.no_signal, 0);
        run(4, 1'b1, G);
        check_eq("term_next_hz_a", ifa.freq_hz,   0);
        check_eq("term_next_ns_a", ifa.no_signal, 1);

        check_eq("sb_leftover", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
